// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage feeding the ALU.
// Decodes an incoming instruction and samples register-file data, then buffers
// the decoded entry in a two-deep elastic buffer (main + skid) so execute-side
// back-pressure never drops or reorders instructions.

`ifndef ALU_ISSUE_DEFS
`define ALU_ISSUE_DEFS
`define WORD_WIDTH    32
`define ALU_CTL_WIDTH 4
`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_SLL   4'd2
`define ALU_SLT   4'd3
`define ALU_SLTU  4'd4
`define ALU_XOR   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_OR    4'd8
`define ALU_AND   4'd9
`define ALU_AUIPC 4'd10
`define ALU_SEQ   4'd11
`define ALU_SNE   4'd12
`define ALU_SGE   4'd13
`define ALU_SGEU  4'd14
`endif

module alu_issue (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [31:0]               in_pc,
    output logic [4:0]                rs1_addr,
    output logic [4:0]                rs2_addr,
    input  logic [31:0]               rs1_data,
    input  logic [31:0]               rs2_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [`WORD_WIDTH-1:0]    out_a,
    output logic [`WORD_WIDTH-1:0]    out_b,
    output logic [`ALU_CTL_WIDTH-1:0] out_ctl,
    output logic [4:0]                out_rd,
    output logic                      out_we,
    output logic                      out_is_branch,
    output logic [`WORD_WIDTH-1:0]    out_br_target,
    output logic                      out_illegal
);

    localparam int W = `WORD_WIDTH;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [W-1:0]              a;
        logic [W-1:0]              b;
        logic [`ALU_CTL_WIDTH-1:0] ctl;
        logic [4:0]                rd;
        logic                      we;
        logic                      is_branch;
        logic [W-1:0]              br_target;
        logic                      illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        a: '0, b: '0, ctl: `ALU_ADD, rd: 5'd0, we: 1'b0,
        is_branch: 1'b0, br_target: '0, illegal: 1'b0
    };

    // Shared funct3 -> ALU op mapping for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [`ALU_CTL_WIDTH-1:0] arith_op(input logic [2:0] f3,
                                                            input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? `ALU_SUB : `ALU_ADD;
            3'b001:  arith_op = `ALU_SLL;
            3'b010:  arith_op = `ALU_SLT;
            3'b011:  arith_op = `ALU_SLTU;
            3'b100:  arith_op = `ALU_XOR;
            3'b101:  arith_op = alt ? `ALU_SRA : `ALU_SRL;
            3'b110:  arith_op = `ALU_OR;
            default: arith_op = `ALU_AND;
        endcase
    endfunction

    entry_t main_q, skid_q, dec;
    logic   main_valid, skid_valid;
    logic   accept, fire;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic signed [W-1:0] imm_i;
    logic signed [W-1:0] imm_b;
    logic                legal;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign imm_i    = W'(signed'(in_instr[31:20]));
    assign imm_b    = W'(signed'({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign fire     = main_valid && out_ready;

    // Decode the offered instruction into a complete issue entry.
    always_comb begin
        dec           = RESET_ENTRY;
        legal         = 1'b0;
        dec.br_target = in_pc + $unsigned(imm_b);
        case (opcode)
            OPC_OP: begin
                dec.a   = rs1_data;
                dec.b   = rs2_data;
                dec.we  = 1'b1;
                dec.ctl = arith_op(funct3, funct7[5]);
                legal   = (funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                dec.a   = rs1_data;
                dec.b   = $unsigned(imm_i);
                dec.we  = 1'b1;
                dec.ctl = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal = 1'b1;
            end
            OPC_LUI: begin
                dec.b  = {in_instr[31:12], 12'b0};
                dec.we = 1'b1;
                legal  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.ctl = `ALU_AUIPC;
                dec.a   = in_pc;
                dec.b   = {12'b0, in_instr[31:12]};
                dec.we  = 1'b1;
                legal   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.a         = rs1_data;
                dec.b         = rs2_data;
                dec.is_branch = 1'b1;
                legal         = 1'b1;
                case (funct3)
                    3'b000:  dec.ctl = `ALU_SEQ;
                    3'b001:  dec.ctl = `ALU_SNE;
                    3'b100:  dec.ctl = `ALU_SLT;
                    3'b101:  dec.ctl = `ALU_SGE;
                    3'b110:  dec.ctl = `ALU_SLTU;
                    3'b111:  dec.ctl = `ALU_SGEU;
                    default: legal   = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec.rd = in_instr[11:7];
            dec.we = dec.we && (in_instr[11:7] != 5'd0);
        end else begin
            // Illegal encodings still flow downstream, but as inert no-ops.
            dec.a         = '0;
            dec.b         = '0;
            dec.ctl       = `ALU_ADD;
            dec.rd        = 5'd0;
            dec.we        = 1'b0;
            dec.is_branch = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    // Main/skid elastic buffer; skid drains into main first to keep program order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= RESET_ENTRY;
            skid_q     <= RESET_ENTRY;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || fire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= accept;
                if (accept)
                    skid_q <= dec;
            end else begin
                main_valid <= accept;
                skid_valid <= 1'b0;
                if (accept)
                    main_q <= dec;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid     = main_valid;
    assign out_a         = main_q.a;
    assign out_b         = main_q.b;
    assign out_ctl       = main_q.ctl;
    assign out_rd        = main_q.rd;
    assign out_we        = main_q.we;
    assign out_is_branch = main_q.is_branch;
    assign out_br_target = main_q.br_target;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue with a queue-based model.

`ifndef ALU_ISSUE_DEFS
`define ALU_ISSUE_DEFS
`define WORD_WIDTH    32
`define ALU_CTL_WIDTH 4
`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_SLL   4'd2
`define ALU_SLT   4'd3
`define ALU_SLTU  4'd4
`define ALU_XOR   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_OR    4'd8
`define ALU_AND   4'd9
`define ALU_AUIPC 4'd10
`define ALU_SEQ   4'd11
`define ALU_SNE   4'd12
`define ALU_SGE   4'd13
`define ALU_SGEU  4'd14
`endif

module tb_alu_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        we;
        logic        is_branch;
        logic [31:0] br_target;
        logic        illegal;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a, out_b, out_br_target;
    logic [3:0]  out_ctl;
    logic [4:0]  out_rd;
    logic        out_we, out_is_branch, out_illegal;

    logic [31:0] regs [32];
    ent_t        mq[$];
    ent_t        got;
    int          checks = 0;
    int          failures = 0;
    logic        last_accept, last_fire;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
    assign got = '{a: out_a, b: out_b, ctl: out_ctl, rd: out_rd, we: out_we,
                   is_branch: out_is_branch, br_target: out_br_target, illegal: out_illegal};

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctl(out_ctl), .out_rd(out_rd), .out_we(out_we),
        .out_is_branch(out_is_branch), .out_br_target(out_br_target), .out_illegal(out_illegal)
    );

    // Reference decode written directly from the RV32I encoding rules.
    function automatic ent_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0]  arith [8];
        logic [3:0]  brtab [8];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] bimm;
        bit          ok;
        ent_t        e;
        arith = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
        brtab = '{`ALU_SEQ, `ALU_SNE, `ALU_ADD, `ALU_ADD, `ALU_SLT, `ALU_SGE, `ALU_SLTU, `ALU_SGEU};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e = '0;
        e.ctl = `ALU_ADD;
        e.br_target = pc + bimm;
        ok = 0;
        if (op == 7'h33) begin
            e.a = r1; e.b = r2; e.we = 1; e.ctl = arith[f3];
            if (f7 == 7'h00) ok = 1;
            else if (f7 == 7'h20 && f3 == 0) begin ok = 1; e.ctl = `ALU_SUB; end
            else if (f7 == 7'h20 && f3 == 5) begin ok = 1; e.ctl = `ALU_SRA; end
        end else if (op == 7'h13) begin
            e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.we = 1; e.ctl = arith[f3];
            if (f3 == 1) ok = (f7 == 7'h00);
            else if (f3 == 5) begin
                ok = (f7 == 7'h00 || f7 == 7'h20);
                if (f7 == 7'h20) e.ctl = `ALU_SRA;
            end else ok = 1;
        end else if (op == 7'h37) begin
            e.b = {ins[31:12], 12'h000}; e.we = 1; ok = 1;
        end else if (op == 7'h17) begin
            e.ctl = `ALU_AUIPC; e.a = pc; e.b = {12'h000, ins[31:12]}; e.we = 1; ok = 1;
        end else if (op == 7'h63) begin
            e.a = r1; e.b = r2; e.is_branch = 1; e.ctl = brtab[f3];
            ok = (f3 != 2 && f3 != 3);
        end
        if (ok) begin
            e.rd = ins[11:7];
            if (e.rd == 0) e.we = 0;
        end else begin
            e.a = 0; e.b = 0; e.ctl = `ALU_ADD; e.we = 0; e.is_branch = 0; e.rd = 0;
            e.illegal = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [6];
        int          k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h33};
        r = $urandom;
        k = $urandom_range(0, 7);
        if (k < 6) r[6:0] = ops[k];
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            k = $urandom_range(0, 3);
            if (k == 0) r[31:25] = 7'h00;
            else if (k == 1) r[31:25] = 7'h20;
        end
        return r;
    endfunction

    // One clock of stimulus; the model advances at the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        ent_t e;
        in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        e = model(ins, pc, regs[ins[19:15]], regs[ins[24:20]]);
        last_accept = iv && (mq.size() < 2);
        last_fire = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (last_fire) void'(mq.pop_front());
            if (last_accept) mq.push_back(e);
        end
        @(negedge clk);
        in_valid = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (got !== ent_t'('0)) begin
            failures++;
            $display("FAIL reset_fields: got %h want 0", got);
        end
        rst_n = 1;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_add();
        regs[1] = 32'd5; regs[2] = 32'd7;
        cycle(1, 32'h002081B3, 32'h0, 1, 0);
        checks++;
        if (out_valid !== 1 || out_a !== 5 || out_b !== 7 || out_ctl !== `ALU_ADD ||
            out_rd !== 3 || out_we !== 1 || out_illegal !== 0) begin
            failures++;
            $display("FAIL add: v=%b a=%0d b=%0d ctl=%0d rd=%0d we=%b want 1 5 7 0 3 1",
                     out_valid, out_a, out_b, out_ctl, out_rd, out_we);
        end
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_auipc();
        cycle(1, 32'h12345297, 32'h100, 1, 0);
        checks++;
        if (out_valid !== 1 || out_ctl !== `ALU_AUIPC || out_a !== 32'h100 ||
            out_b !== 32'h00012345 || out_we !== 1 || out_rd !== 5) begin
            failures++;
            $display("FAIL auipc: ctl=%0d a=%h b=%h we=%b rd=%0d want 10 100 00012345 1 5",
                     out_ctl, out_a, out_b, out_we, out_rd);
        end
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_branch();
        cycle(1, 32'hFE20DCE3, 32'h200, 1, 0);
        checks++;
        if (out_valid !== 1 || out_ctl !== `ALU_SGE || out_we !== 0 ||
            out_is_branch !== 1 || out_br_target !== 32'h1F8) begin
            failures++;
            $display("FAIL bge: ctl=%0d we=%b br=%b tgt=%h want 13 0 1 000001f8",
                     out_ctl, out_we, out_is_branch, out_br_target);
        end
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        ins = '{32'h0000027F, 32'h0230D213};
        for (int i = 0; i < 2; i++) begin
            cycle(1, ins[i], 32'h40, 1, 0);
            checks++;
            if (out_valid !== 1 || out_illegal !== 1 || out_we !== 0 || out_a !== 0 ||
                out_b !== 0 || out_rd !== 0 || out_ctl !== `ALU_ADD) begin
                failures++;
                $display("FAIL illegal%0d: ill=%b we=%b a=%h b=%h rd=%0d", i,
                         out_illegal, out_we, out_a, out_b, out_rd);
            end
        end
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        int idx = 0;
        int fires = 0;
        for (int i = 0; i < 4; i++)
            ins[i] = {7'h00, 5'(i + 1), 5'(i + 2), 3'b000, 5'(i + 10), 7'h33};
        for (int c = 0; c < 20; c++) begin
            if (c == 4) begin
                checks++;
                if (idx !== 2 || in_ready !== 0 || out_valid !== 1) begin
                    failures++;
                    $display("FAIL stall_fill: accepted=%0d in_ready=%b want 2 0", idx, in_ready);
                end
            end
            if (out_valid && mq.size() > 0 && c >= 4) begin
                checks++;
                if (got !== mq[0]) begin
                    failures++;
                    $display("FAIL stream_order: got %h want %h", got, mq[0]);
                end
            end
            cycle(idx < 4, idx < 4 ? ins[idx] : 32'h0, 32'h300 + 32'(4 * idx), c >= 4, 0);
            if (last_accept) idx++;
            if (last_fire) fires++;
        end
        checks++;
        if (fires !== 4 || idx !== 4) begin
            failures++;
            $display("FAIL stream_count: fires=%0d accepted=%0d want 4 4", fires, idx);
        end
    endtask

    task automatic test_flush();
        cycle(1, 32'h002081B3, 0, 0, 0);
        cycle(1, 32'h00310233, 4, 0, 0);
        checks++;
        if (in_ready !== 0 || out_valid !== 1) begin
            failures++;
            $display("FAIL flush_pre: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        cycle(1, 32'h00418133, 8, 0, 1);
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            failures++;
            $display("FAIL flush: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 32'h12345297, 32'h100, 0, 0);
        cycle(1, 32'hFE20DCE3, 32'h200, 0, 0);
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || got !== ent_t'('0)) begin
            failures++;
            $display("FAIL async_reset: v=%b rdy=%b fields=%h want 0 1 0", out_valid, in_ready, got);
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                failures++;
                $display("FAIL rand_hs c%0d: v=%b rdy=%b model_occ=%0d", c, out_valid, in_ready, mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (got !== mq[0]) begin
                    failures++;
                    $display("FAIL rand_entry c%0d: got %h want %h", c, got, mq[0]);
                end
            end
            for (int r = 1; r < 32; r++) regs[r] = $urandom;
            ins = rand_instr();
            cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'(r * 3);
        regs[0] = 0;
        @(negedge clk);
        test_reset();
        test_add();
        test_auipc();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
